// File: rtl/line_select_sequencer_pkg.sv
// rtl/line_select_sequencer_pkg.sv - shared state encoding and line-count helper for line select logic
package line_select_sequencer_pkg;

    // The cache flush controller reuses this encoding, so the values stay fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } lss_state_t;

    // Number of one-hot lines addressed by an index of the given width.
    function automatic int lines_of(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/line_select_sequencer_onehot_decoder.sv
// rtl/line_select_sequencer_onehot_decoder.sv - combinational binary-to-one-hot decoder with enable
module onehot_decoder
    import line_select_sequencer_pkg::*;
#(
    parameter int  SEL_W = 7,
    localparam int LINES = lines_of(SEL_W)
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [LINES-1:0] onehot
);

    // All-zero unless enabled; the index spans exactly LINES positions, so any value is in range.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/line_select_sequencer.sv
// rtl/line_select_sequencer.sv - registered one-hot line enable generator with direct and sweep modes
module line_select_sequencer
    import line_select_sequencer_pkg::*;
#(
    parameter int  SEL_W    = 7,
    parameter bit  SWEEP_EN = 1'b1,
    localparam int LINES    = lines_of(SEL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    input  logic             sweep_start,
    input  logic [SEL_W-1:0] sweep_lo,
    input  logic [SEL_W-1:0] sweep_hi,
    input  logic             stall,
    output logic [LINES-1:0] line_en,
    output logic [SEL_W-1:0] line_idx,
    output logic             line_valid,
    output logic             busy,
    output logic             sweep_done,
    output logic             req_drop
);

    lss_state_t       state_q, state_d;
    logic [SEL_W-1:0] cursor_q, cursor_d;
    logic [SEL_W-1:0] hi_q, hi_d;

    logic [SEL_W-1:0] dec_idx;
    logic             dec_en;
    logic [LINES-1:0] dec_onehot;
    logic [SEL_W-1:0] idx_d;
    logic             valid_d;
    logic             done_d;
    logic             drop_d;

    // One decoder serves both modes; the index is muxed ahead of it.
    onehot_decoder #(
        .SEL_W (SEL_W)
    ) u_decoder (
        .idx    (dec_idx),
        .en     (dec_en),
        .onehot (dec_onehot)
    );

    // Sequencer state, sweep cursor and captured upper bound.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            hi_q     <= hi_d;
        end
    end

    // Next state and next registered output values; the index mux is forced to zero when
    // nothing is issued so an undriven sel can never reach the outputs.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        hi_d     = hi_q;
        dec_en   = 1'b0;
        dec_idx  = '0;
        idx_d    = '0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (SWEEP_EN && sweep_start) begin
                    // Sweep has priority; a simultaneous direct request is lost.
                    cursor_d = sweep_lo;
                    hi_d     = sweep_hi;
                    state_d  = ST_SWEEP;
                    drop_d   = sel_valid;
                end else if (sel_valid) begin
                    dec_en  = 1'b1;
                    dec_idx = sel;
                    idx_d   = sel;
                    valid_d = 1'b1;
                end
            end
            ST_SWEEP: begin
                drop_d = sel_valid;
                if (!stall) begin
                    dec_en  = 1'b1;
                    dec_idx = cursor_q;
                    idx_d   = cursor_q;
                    valid_d = 1'b1;
                    if (cursor_q == hi_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // Natural SEL_W-bit wrap handles lo > hi ranges.
                        cursor_d = cursor_q + SEL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                drop_d  = sel_valid;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output registers: everything the block drives comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_en    <= '0;
            line_idx   <= '0;
            line_valid <= 1'b0;
            sweep_done <= 1'b0;
            req_drop   <= 1'b0;
        end else begin
            line_en    <= dec_onehot;
            line_idx   <= idx_d;
            line_valid <= valid_d;
            sweep_done <= done_d;
            req_drop   <= drop_d;
        end
    end

    assign busy = SWEEP_EN && (state_q == ST_SWEEP);

endmodule

// File: tb/tb_line_select_sequencer.sv
// tb/tb_line_select_sequencer.sv - self-checking bench for line_select_sequencer
module tb_line_select_sequencer;

    localparam int SEL_W = 7;
    localparam int LINES = 128;

    logic             clk;
    logic             rst;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             sweep_start;
    logic [SEL_W-1:0] sweep_lo;
    logic [SEL_W-1:0] sweep_hi;
    logic             stall;
    logic [LINES-1:0] line_en;
    logic [SEL_W-1:0] line_idx;
    logic             line_valid;
    logic             busy;
    logic             sweep_done;
    logic             req_drop;

    int checks = 0;
    int passes = 0;
    bit cmp_on = 1'b0;

    line_select_sequencer #(
        .SEL_W    (SEL_W),
        .SWEEP_EN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .sweep_start (sweep_start),
        .sweep_lo    (sweep_lo),
        .sweep_hi    (sweep_hi),
        .stall       (stall),
        .line_en     (line_en),
        .line_idx    (line_idx),
        .line_valid  (line_valid),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .req_drop    (req_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [LINES-1:0] act, input logic [LINES-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is the list of indices it must emit, stall only delays the list.
    int               m_mode = 0;   // 0 idle, 1 sweeping, 2 done cycle
    int               m_q[$];
    logic [LINES-1:0] e_en    = '0;
    logic [SEL_W-1:0] e_idx   = '0;
    logic             e_valid = 1'b0;
    logic             e_busy  = 1'b0;
    logic             e_done  = 1'b0;
    logic             e_drop  = 1'b0;

    always @(posedge clk or posedge rst) begin
        int n;
        int v;
        if (rst) begin
            m_mode = 0;
            m_q.delete();
            e_en = '0; e_idx = '0; e_valid = 1'b0; e_done = 1'b0; e_drop = 1'b0;
        end else begin
            e_en = '0; e_idx = '0; e_valid = 1'b0; e_done = 1'b0; e_drop = 1'b0;
            if (m_mode == 0) begin
                if (sweep_start) begin
                    n = ((int'(sweep_hi) - int'(sweep_lo) + LINES) % LINES) + 1;
                    for (int k = 0; k < n; k++) m_q.push_back((int'(sweep_lo) + k) % LINES);
                    m_mode = 1;
                    e_drop = sel_valid;
                end else if (sel_valid) begin
                    e_en = '0;
                    e_en[sel] = 1'b1;
                    e_idx = sel;
                    e_valid = 1'b1;
                end
            end else if (m_mode == 1) begin
                e_drop = sel_valid;
                if (!stall) begin
                    v = m_q.pop_front();
                    e_en = '0;
                    e_en[v] = 1'b1;
                    e_idx = SEL_W'(v);
                    e_valid = 1'b1;
                    if (m_q.size() == 0) m_mode = 2;
                end
            end else begin
                e_done = 1'b1;
                e_drop = sel_valid;
                m_mode = 0;
            end
        end
        e_busy = (m_mode == 1);
    end

    // Every-cycle comparison against the model plus the output invariants.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("line_en", line_en, e_en);
            chk("line_idx", LINES'(line_idx), LINES'(e_idx));
            chk("line_valid", LINES'(line_valid), LINES'(e_valid));
            chk("busy", LINES'(busy), LINES'(e_busy));
            chk("sweep_done", LINES'(sweep_done), LINES'(e_done));
            chk("req_drop", LINES'(req_drop), LINES'(e_drop));
            chk("onehot_inv", LINES'($countones(line_en) <= 1), LINES'(1));
            chk("idle_zero_inv", LINES'(line_valid || (line_en == '0)), LINES'(1));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_sweep(input int lo, input int hi);
        tick();
        sweep_start = 1'b1;
        sweep_lo = SEL_W'(lo);
        sweep_hi = SEL_W'(hi);
        tick();
        sweep_start = 1'b0;
        chk("sweep_entry_busy", LINES'(busy), LINES'(1));
        chk("sweep_entry_valid", LINES'(line_valid), LINES'(0));
    endtask

    int               wrap_seq[4] = '{126, 127, 0, 1};
    logic [LINES-1:0] bit127;
    int               seen;
    bit               got_done;

    initial begin
        bit127 = '0;
        bit127[127] = 1'b1;
        rst = 1'b1;
        sel = '0; sel_valid = 1'b0; sweep_start = 1'b0;
        sweep_lo = '0; sweep_hi = '0; stall = 1'b0;
        tick();
        tick();
        chk("reset_line_en", line_en, '0);
        chk("reset_valid", LINES'(line_valid), LINES'(0));
        chk("reset_busy", LINES'(busy), LINES'(0));
        chk("reset_done", LINES'(sweep_done), LINES'(0));
        rst = 1'b0;
        cmp_on = 1'b1;

        // Direct request, then X on sel while idle.
        tick();
        sel = 7'd5; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0; sel = 'x;
        chk("direct5_en", line_en, 128'h20);
        chk("direct5_idx", LINES'(line_idx), LINES'(5));
        chk("direct5_valid", LINES'(line_valid), LINES'(1));
        tick();
        chk("direct5_after_en", line_en, '0);
        chk("direct5_after_valid", LINES'(line_valid), LINES'(0));

        // Back-to-back direct requests, with stall toggling (no effect in direct mode).
        for (int k = 10; k < 14; k++) begin
            sel = SEL_W'(k); sel_valid = 1'b1; stall = k[0];
            tick();
        end
        sel_valid = 1'b0; stall = 1'b0;
        tick();

        // Sweep 3..6.
        start_sweep(3, 6);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sweep36_idx", LINES'(line_idx), LINES'(3 + k));
            chk("sweep36_valid", LINES'(line_valid), LINES'(1));
            chk("sweep36_busy", LINES'(busy), LINES'(k < 3));
        end
        tick();
        chk("sweep36_done", LINES'(sweep_done), LINES'(1));
        chk("sweep36_done_valid", LINES'(line_valid), LINES'(0));

        // Wrapping sweep 126..1.
        start_sweep(126, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wrap_idx", LINES'(line_idx), LINES'(wrap_seq[k]));
            if (k == 1) chk("wrap_en127", line_en, bit127);
        end
        tick();
        chk("wrap_done", LINES'(sweep_done), LINES'(1));

        // Stall: 0, gap, gap, 1, 2.
        start_sweep(0, 2);
        tick();
        chk("stall_idx0", LINES'(line_idx), LINES'(0));
        stall = 1'b1;
        tick();
        chk("stall_gap1_en", line_en, '0);
        chk("stall_gap1_valid", LINES'(line_valid), LINES'(0));
        tick();
        chk("stall_gap2_valid", LINES'(line_valid), LINES'(0));
        stall = 1'b0;
        tick();
        chk("stall_idx1", LINES'(line_idx), LINES'(1));
        tick();
        chk("stall_idx2", LINES'(line_idx), LINES'(2));
        tick();
        chk("stall_done", LINES'(sweep_done), LINES'(1));

        // Conflicts: start+request, request and start during SWEEP, request during DONE.
        tick();
        sweep_start = 1'b1; sel_valid = 1'b1; sel = 7'd33;
        sweep_lo = 7'd8; sweep_hi = 7'd9;
        tick();
        chk("conflict_drop0", LINES'(req_drop), LINES'(1));
        chk("conflict_busy", LINES'(busy), LINES'(1));
        sel = 7'd44; sel_valid = 1'b1; sweep_start = 1'b1; sweep_lo = 7'd50;
        tick();
        chk("conflict_idx8", LINES'(line_idx), LINES'(8));
        chk("conflict_drop1", LINES'(req_drop), LINES'(1));
        sel_valid = 1'b0; sweep_start = 1'b0;
        tick();
        chk("conflict_idx9", LINES'(line_idx), LINES'(9));
        chk("conflict_nodrop", LINES'(req_drop), LINES'(0));
        sel = 7'd60; sel_valid = 1'b1;
        tick();
        chk("conflict_done", LINES'(sweep_done), LINES'(1));
        chk("conflict_drop_done", LINES'(req_drop), LINES'(1));
        sel = 7'd20; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        chk("post_done_direct_idx", LINES'(line_idx), LINES'(20));
        chk("post_done_direct_valid", LINES'(line_valid), LINES'(1));

        // Full-range sweep: exactly LINES lines, bounded wait for the done pulse.
        start_sweep(0, LINES - 1);
        seen = 0;
        got_done = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            tick();
            if (line_valid) seen++;
            if (sweep_done) got_done = 1'b1;
        end
        chk("full_sweep_done_seen", LINES'(got_done), LINES'(1));
        chk("full_sweep_count", LINES'(seen), LINES'(LINES));

        // Async reset mid-sweep after index 4 of 0..10.
        start_sweep(0, 10);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_sweep_idx", LINES'(line_idx), LINES'(k));
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", line_en, '0);
        chk("async_rst_valid", LINES'(line_valid), LINES'(0));
        chk("async_rst_busy", LINES'(busy), LINES'(0));
        chk("async_rst_idx", LINES'(line_idx), LINES'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_no_done", LINES'(sweep_done), LINES'(0));
        end
        rst = 1'b0;
        sel = 7'd127; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        chk("after_rst_en127", line_en, bit127);
        chk("after_rst_idx127", LINES'(line_idx), LINES'(127));
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("after_rst_quiet_done", LINES'(sweep_done), LINES'(0));
        end

        tick();
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
